// File: rtl/router_fifo_reader_if.sv
// router_fifo_reader_if: FIFO read port plus output-port handshake of one router FIFO reader
interface router_fifo_reader_if #(parameter int DATA_W = 8);
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_data;
  logic              fifo_read_enb;
  logic              read_enb;
  logic              vld_out;
  logic [DATA_W-1:0] data_out;
  logic              sop_out;
  logic              soft_reset;
  logic              pkt_done;
  logic              frame_err;
  modport master (
    input  fifo_empty, fifo_data, read_enb,
    output fifo_read_enb, vld_out, data_out, sop_out, soft_reset, pkt_done, frame_err
  );
  modport slave (
    output fifo_empty, fifo_data, read_enb,
    input  fifo_read_enb, vld_out, data_out, sop_out, soft_reset, pkt_done, frame_err
  );
endinterface

// File: rtl/router_fifo_reader.sv
// router_fifo_reader: drains one router FIFO toward an output port, tracks packet framing and stall timeout
module router_fifo_reader #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 6,
  parameter int TIMEOUT = 30
) (
  input logic clock,
  input logic resetn,
  router_fifo_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;
  localparam int SC_W = $clog2(TIMEOUT);
  localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);
  localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(TIMEOUT - 1);
  state_t state;
  logic [LEN_W:0] bytes_left;
  logic [SC_W-1:0] stall_cnt;
  logic accept, timeout, hdr;
  logic [LEN_W:0] len;
  assign accept  = state == PRESENT && bus.read_enb;
  assign timeout = state == PRESENT && !bus.read_enb && stall_cnt == SC_LAST;
  // no pop while held in reset or during the soft_reset cycle, so the FIFO can flush first
  assign bus.fifo_read_enb = resetn && !bus.fifo_empty && ((state == IDLE && !bus.soft_reset) || accept);
  assign hdr = bus.fifo_data[DATA_W];
  assign len = {1'b0, bus.fifo_data[DATA_W-1:2]} + ONE;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state          <= IDLE;
      bytes_left     <= '0;
      stall_cnt      <= '0;
      bus.vld_out    <= 1'b0;
      bus.data_out   <= '0;
      bus.sop_out    <= 1'b0;
      bus.soft_reset <= 1'b0;
      bus.pkt_done   <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.soft_reset <= 1'b0;
      bus.pkt_done   <= 1'b0;
      bus.frame_err  <= 1'b0;
      case (state)
        IDLE: if (bus.fifo_read_enb) state <= FETCH;
        FETCH: begin
          {bus.sop_out, bus.data_out} <= bus.fifo_data;
          bus.vld_out   <= 1'b1;
          bytes_left    <= hdr ? len : bytes_left;
          bus.frame_err <= hdr ? bytes_left != '0 : bytes_left == '0;
          state         <= PRESENT;
        end
        PRESENT:
          if (accept) begin
            bus.vld_out  <= 1'b0;
            stall_cnt    <= '0;
            if (!bus.sop_out && bytes_left != '0) bytes_left <= bytes_left - ONE;
            bus.pkt_done <= !bus.sop_out && bytes_left == ONE;
            state        <= bus.fifo_read_enb ? FETCH : IDLE;
          end else if (timeout) begin
            bus.soft_reset <= 1'b1;
            bus.vld_out    <= 1'b0;
            bytes_left     <= '0;
            stall_cnt      <= '0;
            state          <= IDLE;
          end else
            stall_cnt <= stall_cnt + SC_ONE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_router_fifo_reader.sv
// tb_router_fifo_reader: directed checks of the router FIFO reader against a small FIFO model
module tb_router_fifo_reader;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;
  router_fifo_reader_if #(.DATA_W(8)) bus();
  router_fifo_reader #(.DATA_W(8), .LEN_W(6), .TIMEOUT(30)) dut (.clock(clock), .resetn(resetn), .bus(bus));
  logic [8:0] mem [256];
  int wp = 0, rp = 0;
  logic flush = 1'b0;
  assign bus.fifo_empty = (rp == wp);
  always @(posedge clock)
    if (bus.soft_reset || flush) rp <= wp;
    else if (bus.fifo_read_enb && rp != wp) begin
      bus.fifo_data <= mem[rp];
      rp <= rp + 1;
    end
  int cyc = 0, nacc = 0, npop = 0, n_pkt = 0, n_ferr = 0, n_srst = 0, pkt_cyc = 0, bad_pop = 0, dbl = 0;
  logic [7:0] acc_d [64];
  logic       acc_s [64];
  int         acc_c [64];
  logic [2:0] prev = '0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.vld_out && bus.read_enb) begin
      acc_d[nacc] <= bus.data_out;
      acc_s[nacc] <= bus.sop_out;
      acc_c[nacc] <= cyc;
      nacc <= nacc + 1;
    end
    if (bus.fifo_read_enb) npop <= npop + 1;
    if (bus.fifo_read_enb && bus.fifo_empty) bad_pop <= bad_pop + 1;
    if (bus.pkt_done) begin
      n_pkt <= n_pkt + 1;
      pkt_cyc <= cyc;
    end
    if (bus.frame_err) n_ferr <= n_ferr + 1;
    if (bus.soft_reset) n_srst <= n_srst + 1;
    if (|(prev & {bus.pkt_done, bus.frame_err, bus.soft_reset})) dbl <= dbl + 1;
    prev <= {bus.pkt_done, bus.frame_err, bus.soft_reset};
  end
  int vecs = 0, errs = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [8:0] v);
    mem[wp] = v;
    wp++;
  endtask
  task automatic wait_byte(input string tag, input logic [7:0] d);
    int k = 0;
    while (!(bus.vld_out && bus.data_out == d) && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(k < 100), 1);
  endtask
  logic [7:0] exp1 [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
  initial begin
    int p0, f0, a0, k;
    logic ok;
    bus.read_enb = 1'b0;
    foreach (exp1[i]) push({i == 0, exp1[i]});
    repeat (3) @(negedge clock);
    chk("rst_vld", bus.vld_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_sop", bus.sop_out, 0);
    chk("rst_srst", bus.soft_reset, 0);
    chk("rst_pkt", bus.pkt_done, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_pop", bus.fifo_read_enb, 0);
    resetn = 1'b1;
    #1 chk("first_pop", bus.fifo_read_enb, 1);
    bus.read_enb = 1'b1;
    repeat (20) @(negedge clock);
    chk("p1_count", nacc, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("p1_data%0d", i), acc_d[i], exp1[i]);
      chk($sformatf("p1_sop%0d", i), acc_s[i], i == 0);
      if (i > 0) chk($sformatf("p1_gap%0d", i), acc_c[i] - acc_c[i-1], 2);
    end
    chk("p1_pkt", n_pkt, 1);
    chk("p1_pkt_time", pkt_cyc, acc_c[4] + 1);
    chk("p1_ferr", n_ferr, 0);
    foreach (exp1[i]) push({i == 0, exp1[i]});
    wait_byte("stall_reach", 8'h22);
    bus.read_enb = 1'b0;
    p0 = npop;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (!(bus.vld_out && bus.data_out == 8'h22)) ok = 1'b0;
    end
    chk("stall_stable", ok, 1);
    chk("stall_hold", bus.data_out, 8'h22);
    chk("stall_no_pop", npop, p0);
    chk("stall_no_srst", n_srst, 0);
    bus.read_enb = 1'b1;
    repeat (10) @(negedge clock);
    chk("p2_count", nacc, 10);
    chk("p2_d33", acc_d[8], 8'h33);
    chk("p2_par", acc_d[9], 8'h0C);
    chk("p2_pkt", n_pkt, 2);
    bus.read_enb = 1'b0;
    f0 = n_ferr;
    a0 = nacc;
    push(9'h108); push(9'h0AA); push(9'h0BB); push(9'h019);
    k = 0;
    while (!bus.vld_out && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("to_present", 32'(k < 100), 1);
    ok = 1'b1;
    repeat (29) begin
      @(negedge clock);
      if (!bus.vld_out || bus.soft_reset) ok = 1'b0;
    end
    chk("to_hold29", ok, 1);
    @(negedge clock);
    chk("to_srst", bus.soft_reset, 1);
    chk("to_vld", bus.vld_out, 0);
    chk("to_no_pop", bus.fifo_read_enb, 0);
    @(negedge clock);
    chk("to_srst_once", bus.soft_reset, 0);
    chk("to_no_accept", nacc, a0);
    push(9'h104); push(9'h055); push(9'h051);
    bus.read_enb = 1'b1;
    repeat (12) @(negedge clock);
    chk("to_next_ferr", n_ferr, f0);
    chk("to_next_count", nacc, 13);
    chk("to_next_sop", acc_s[10], 1);
    chk("to_next_par", acc_d[12], 8'h51);
    chk("to_next_pkt", n_pkt, 3);
    push(9'h108); push(9'h001); push(9'h104); push(9'h002); push(9'h006);
    repeat (20) @(negedge clock);
    chk("fr_ferr", n_ferr, 1);
    chk("fr_pkt", n_pkt, 4);
    chk("fr_count", nacc, 18);
    chk("fr_par", acc_d[17], 8'h06);
    push(9'h10C); push(9'h001); push(9'h002); push(9'h003); push(9'h00C);
    wait_byte("mr_reach", 8'h02);
    resetn = 1'b0;
    flush = 1'b1;
    #1;
    chk("mr_vld", bus.vld_out, 0);
    chk("mr_data", bus.data_out, 0);
    chk("mr_sop", bus.sop_out, 0);
    chk("mr_pop", bus.fifo_read_enb, 0);
    @(negedge clock);
    flush = 1'b0;
    resetn = 1'b1;
    push(9'h100); push(9'h000);
    repeat (10) @(negedge clock);
    chk("mr_ferr", n_ferr, 1);
    chk("mr_count", nacc, 22);
    chk("mr_len0_sop", acc_s[20], 1);
    chk("mr_len0_par_sop", acc_s[21], 0);
    chk("mr_len0_pkt", n_pkt, 5);
    chk("pop_when_empty", bad_pop, 0);
    chk("pulse_double", dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
